// File: rtl/seg7_pkg.sv
// Shared types and constants for the 6-digit multiplexed seven-segment driver.
package seg7_pkg;

    localparam int NUM_DIGITS = 6;
    localparam int SEG_W      = 7;

    localparam logic [SEG_W-1:0] SEG_OFF_AL = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_OFF_AH = 7'h00;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    function automatic logic [NUM_DIGITS-1:0] anode_sel(input logic [2:0] d);
        return ~(NUM_DIGITS'(1) << d);
    endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// Slot counter shared by the blanking and drive phases; flags the last cycle
// of a slot so the FSM can advance.
module seg7_slot_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic [W-1:0] lim,
    output logic         tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign tc = (cnt == lim);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 6-digit seven-segment scan driver with frame snapshot.
// Optional SEG7_DIM_EN adds a bright[3:0] port for PWM anode dimming.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DRIVE_CYCLES = 49990,
    parameter int BLANK_CYCLES = 10,
    parameter int SEG_ACT_LOW  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [41:0] segment,
    output logic [6:0]  seg_out,
    output logic [5:0]  an_n,
    output logic        frame_start
`ifdef SEG7_DIM_EN
    ,
    input  logic [3:0]  bright
`endif
);

    localparam int MAXC = (DRIVE_CYCLES > BLANK_CYCLES) ? DRIVE_CYCLES : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [SEG_W-1:0] SEG_OFF = (SEG_ACT_LOW != 0) ? SEG_OFF_AL : SEG_OFF_AH;

    state_t      state;
    logic [2:0]  dig;
    logic [41:0] snap;
    logic        tc;
    logic        clr;
    logic [CW-1:0] lim;
    logic [SEG_W-1:0] raw;
    logic [SEG_W-1:0] lit;
    logic        drive_en;

    always_comb begin
        lim = (state == ST_BLANK) ? CW'(BLANK_CYCLES - 1) : CW'(DRIVE_CYCLES - 1);
        clr = (state == ST_LOAD) || tc;
        raw = snap[SEG_W*dig +: SEG_W];
        lit = (SEG_ACT_LOW != 0) ? ~raw : raw;
    end

    seg7_slot_timer #(
        .W(CW)
    ) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr),
        .lim  (lim),
        .tc   (tc)
    );

`ifdef SEG7_DIM_EN
    logic [3:0] pwm;
    logic [3:0] bright_q;

    // Brightness is latched per frame so a mid-frame change cannot tear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm      <= '0;
            bright_q <= '0;
        end else begin
            pwm <= pwm + 4'd1;
            if (state == ST_LOAD) begin
                bright_q <= bright;
            end
        end
    end

    assign drive_en = ({1'b0, pwm} < ({1'b0, bright_q} + 5'd1));
`else
    assign drive_en = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_LOAD;
            dig   <= '0;
            snap  <= '0;
        end else begin
            unique case (state)
                ST_LOAD: begin
                    snap  <= segment;
                    dig   <= '0;
                    state <= ST_BLANK;
                end
                ST_BLANK: begin
                    if (tc) begin
                        state <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (tc) begin
                        if (dig == 3'(NUM_DIGITS - 1)) begin
                            state <= ST_LOAD;
                        end else begin
                            dig   <= dig + 3'd1;
                            state <= ST_BLANK;
                        end
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

    // Outputs trail the state by one cycle; anode and cathode move together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_out     <= SEG_OFF;
            an_n        <= '1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= (state == ST_LOAD);
            seg_out     <= SEG_OFF;
            an_n        <= '1;
            if (state == ST_DRIVE) begin
                seg_out <= lit;
                if (drive_en) begin
                    an_n <= anode_sel(dig);
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver with DRIVE_CYCLES=4, BLANK_CYCLES=2.
// Define SEG7_DIM_EN to also exercise the brightness PWM path.
module tb_seg7_scan_driver;

    localparam int DC = 4;
    localparam int BC = 2;
    localparam int SLOT = BC + DC;
    localparam int FR = 1 + 6 * SLOT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [41:0] segment = '0;
    logic [6:0]  seg_out;
    logic [5:0]  an_n;
    logic        frame_start;
`ifdef SEG7_DIM_EN
    logic [3:0]  bright = 4'd15;
`endif

    int checks = 0;
    int passed = 0;
    int n = 0;
    int last_fs = -1;
    int mbright = 15;
    logic [41:0] msnap = '0;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .DRIVE_CYCLES(DC),
        .BLANK_CYCLES(BC),
        .SEG_ACT_LOW (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .segment    (segment),
        .seg_out    (seg_out),
        .an_n       (an_n),
        .frame_start(frame_start)
`ifdef SEG7_DIM_EN
        ,
        .bright     (bright)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, n, got, exp);
        end
    endtask

    // n = cycles since reset release; frame sample taken on each frame's first edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n = 0;
            last_fs = -1;
        end else begin
            n++;
            if ((n - 1) % FR == 0) begin
                msnap = segment;
`ifdef SEG7_DIM_EN
                mbright = int'(bright);
`endif
            end
        end
    end

    function automatic void model(input int k, output logic [6:0] es,
                                  output logic [5:0] ea, output logic ef);
        int q, r, d, s;
        es = 7'h7F;
        ea = 6'h3F;
        ef = 1'b0;
        if (k >= 1) begin
            q = (k - 1) % FR;
            ef = (q == 0);
            if (q != 0) begin
                r = q - 1;
                d = r / SLOT;
                s = r % SLOT;
                if (s >= BC) begin
                    es = 7'h7F ^ 7'((msnap >> (7 * d)) & 42'h7F);
                    if (((k - 1) % 16) < mbright + 1) begin
                        ea = 6'h3F ^ 6'(1 << d);
                    end
                end
            end
        end
    endfunction

    always @(negedge clk) begin
        logic [6:0] es;
        logic [5:0] ea;
        logic       ef;
        model(n, es, ea, ef);
        chk("seg_out", 64'(seg_out), 64'(es));
        chk("an_n", 64'(an_n), 64'(ea));
        chk("frame_start", 64'(frame_start), 64'(ef));
        chk("an_onehot", 64'($countones(~an_n) <= 1), 64'd1);
        if (frame_start) begin
            if (last_fs >= 0) begin
                chk("fs_period", 64'(n - last_fs), 64'(FR));
            end
            last_fs = n;
        end
    end

    task automatic wait_n(input int k);
        int t = 0;
        while (n != k && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (n != k) begin
            checks++;
            $display("FAIL wait_n: reached cycle %0d, expected %0d", n, k);
        end
    endtask

    initial begin
        segment = 42'h0_3F06_5B4F;
        repeat (3) @(negedge clk);
        chk("rst_an", 64'(an_n), 64'h3F);
        chk("rst_seg", 64'(seg_out), 64'h7F);
        chk("rst_fs", 64'(frame_start), 64'h0);
        #2 rst_n = 1'b1;

        wait_n(1);
        chk("lit_fs1", 64'(frame_start), 64'h1);
        wait_n(4);
        chk("lit_d0_an", 64'(an_n), 64'h3E);
        chk("lit_d0_seg", 64'(seg_out), 64'h30);
        wait_n(8);
        chk("lit_gap_an", 64'(an_n), 64'h3F);
        wait_n(10);
        chk("lit_d1_an", 64'(an_n), 64'h3D);
        chk("lit_d1_seg", 64'(seg_out), 64'h49);
        wait_n(17);
        #1 segment = 42'h1;
        wait_n(22);
        chk("lit_d3_old_an", 64'(an_n), 64'h37);
        chk("lit_d3_old_seg", 64'(seg_out), 64'h07);
        wait_n(37);
        chk("lit_d5_an", 64'(an_n), 64'h1F);
        chk("lit_d5_seg", 64'(seg_out), 64'h7F);
        wait_n(38);
        chk("lit_fs2", 64'(frame_start), 64'h1);
        wait_n(41);
        chk("lit_new_an", 64'(an_n), 64'h3E);
        chk("lit_new_seg", 64'(seg_out), 64'h7E);

        wait_n(140);
        chk("lit_d4_an", 64'(an_n), 64'h2F);
        #2 rst_n = 1'b0;
        #1;
        chk("async_an", 64'(an_n), 64'h3F);
        chk("async_seg", 64'(seg_out), 64'h7F);
        chk("async_fs", 64'(frame_start), 64'h0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        wait_n(1);
        chk("restart_fs", 64'(frame_start), 64'h1);
        wait_n(4);
        chk("restart_an", 64'(an_n), 64'h3E);
        chk("restart_seg", 64'(seg_out), 64'h7E);

`ifdef SEG7_DIM_EN
        #1 bright = 4'd3;
        wait_n(30);
        #1 segment = 42'h0_3F06_5B4F;
        wait_n(60);
        #1 bright = 4'd0;
        wait_n(120);
`else
        #1 segment = 42'h0_3F06_5B4F;
        wait_n(80);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
